cpu_mem_arbiter: RTL and testbench

//  Responder end of the CPU's split I/D memory protocol (read/write held until a 1-cycle resp).

---
 rtl/cpu_mem_arbiter_pkg.sv | 12 +
 rtl/cpu_mem_arbiter_rr_arbiter2.sv | 21 ++
 rtl/cpu_mem_arbiter.sv | 111 +++++++++++
 tb/tb_cpu_mem_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_arbiter_pkg.sv
// cpu_mem_arbiter_pkg: shared types for the I/D memory arbiter
package cpu_mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, SERVE, RESP} arb_state_t;
  typedef enum logic {PORT_I, PORT_D} arb_port_t;
  typedef struct packed {
    logic        read;
    logic        write;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/cpu_mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant between the I and D ports
module rr_arbiter2
  import cpu_mem_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_req_i,
  input  logic      i_req_d,
  input  logic      i_take,
  output arb_port_t o_grant,
  output logic      o_valid
);
  arb_port_t r_last;
  assign o_valid = i_req_i | i_req_d;
  assign o_grant = (i_req_i & i_req_d) ? ((r_last == PORT_I) ? PORT_D : PORT_I)
                                       : (i_req_d ? PORT_D : PORT_I);
  // remember the last port granted so a tie goes to the other one
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_last <= PORT_I;
    else if (i_take && o_valid) r_last <= o_grant;
endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: round-robin I/D requester arbitration onto one physical memory port
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 1024
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [3:0]  mem_byte_enable_i,
  input  logic [31:0] mem_address_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_resp_i,
  output logic [31:0] mem_rdata_i,
  input  logic        mem_read_d,
  input  logic        mem_write_d,
  input  logic [3:0]  mem_byte_enable_d,
  input  logic [31:0] mem_address_d,
  input  logic [31:0] mem_wdata_d,
  output logic        mem_resp_d,
  output logic [31:0] mem_rdata_d,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [3:0]  pmem_byte_enable,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [31:0] pmem_rdata,
  output logic        proto_err,
  output logic        timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  arb_state_t    r_state, w_next;
  arb_port_t     r_port, w_grant;
  mem_req_t      r_req, w_req_sel;
  logic          w_valid, w_idle, w_wait;
  logic [31:0]   r_rdata;
  logic [CW-1:0] r_cnt;
  logic          r_proto_err, r_timeout_err;
  assign w_idle = r_state == IDLE;
  assign w_wait = (r_state == SERVE) && !pmem_resp;
  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .i_req_i (mem_read_i | mem_write_i),
    .i_req_d (mem_read_d | mem_write_d),
    .i_take  (w_idle),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );
  // a simultaneous read+write is served as the write alone
  assign w_req_sel = (w_grant == PORT_D)
    ? {mem_read_d & ~mem_write_d, mem_write_d, mem_byte_enable_d, mem_address_d, mem_wdata_d}
    : {mem_read_i & ~mem_write_i, mem_write_i, mem_byte_enable_i, mem_address_i, mem_wdata_i};
  assign pmem_byte_enable = r_req.be;
  assign pmem_address     = r_req.addr;
  assign pmem_wdata       = r_req.wdata;
  assign proto_err        = r_proto_err;
  assign timeout_err      = r_timeout_err;
  // state register; async reset drops strobes and responses at once
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  // next state plus strobe and response decode from the registered state
  always_comb begin
    w_next      = r_state;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    mem_resp_i  = 1'b0;
    mem_resp_d  = 1'b0;
    mem_rdata_i = '0;
    mem_rdata_d = '0;
    unique case (r_state)
      IDLE:  w_next = w_valid ? SERVE : IDLE;
      SERVE: begin
        w_next     = pmem_resp ? RESP : SERVE;
        pmem_read  = r_req.read;
        pmem_write = r_req.write;
      end
      RESP: begin
        w_next      = IDLE;
        mem_resp_i  = r_port == PORT_I;
        mem_resp_d  = r_port == PORT_D;
        mem_rdata_i = (r_port == PORT_I) ? r_rdata : '0;
        mem_rdata_d = (r_port == PORT_D) ? r_rdata : '0;
      end
      default: w_next = IDLE;
    endcase
  end
  // request latch, read-data capture, saturating wait counter and sticky flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_req         <= '0;
      r_port        <= PORT_I;
      r_rdata       <= '0;
      r_cnt         <= '0;
      r_proto_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_idle && w_valid) begin
        r_req  <= w_req_sel;
        r_port <= w_grant;
        r_cnt  <= '0;
      end
      if (w_idle && ((mem_read_i & mem_write_i) | (mem_read_d & mem_write_d))) r_proto_err <= 1'b1;
      if (r_state == SERVE && pmem_resp) r_rdata <= r_req.read ? pmem_rdata : '0;
      if (w_wait && r_cnt != CW'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
      if (w_wait && r_cnt == CW'(TIMEOUT - 1)) r_timeout_err <= 1'b1;
    end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: scoreboard bench for the I/D memory arbiter
module tb_cpu_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b0;
  logic        mem_read_i = 0, mem_write_i = 0, mem_read_d = 0, mem_write_d = 0;
  logic [3:0]  mem_byte_enable_i = 0, mem_byte_enable_d = 0;
  logic [31:0] mem_address_i = 0, mem_wdata_i = 0, mem_address_d = 0, mem_wdata_d = 0;
  logic        mem_resp_i, mem_resp_d;
  logic [31:0] mem_rdata_i, mem_rdata_d;
  logic        pmem_read, pmem_write, pmem_resp = 0;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_address, pmem_wdata, pmem_rdata = 0;
  logic        proto_err, timeout_err;
  typedef struct {logic port; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_err = 0;
  int delay = 0, wcnt = 0;
  logic hold = 0, stray = 0;
  logic [31:0] rd_val = 0;

  cpu_mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_byte_enable_i(mem_byte_enable_i),
    .mem_address_i(mem_address_i), .mem_wdata_i(mem_wdata_i), .mem_resp_i(mem_resp_i), .mem_rdata_i(mem_rdata_i),
    .mem_read_d(mem_read_d), .mem_write_d(mem_write_d), .mem_byte_enable_d(mem_byte_enable_d),
    .mem_address_d(mem_address_d), .mem_wdata_d(mem_wdata_d), .mem_resp_d(mem_resp_d), .mem_rdata_d(mem_rdata_d),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_byte_enable(pmem_byte_enable),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .proto_err(proto_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one clock: scoreboard the cpu responses, then play the memory
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (mem_resp_i || mem_resp_d) begin
      if (exp_q.size() == 0) chk("sb_extra_resp", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_port", {31'b0, mem_resp_d}, {31'b0, e.port});
        chk("sb_one_resp", {31'b0, mem_resp_i & mem_resp_d}, 0);
        chk("sb_rdata", mem_resp_d ? mem_rdata_d : mem_rdata_i, e.data);
      end
      if (mem_resp_i) begin mem_read_i = 0; mem_write_i = 0; end
      if (mem_resp_d) begin mem_read_d = 0; mem_write_d = 0; end
    end
    if (pmem_resp) pmem_resp = 0;
    else if (stray) begin pmem_resp = 1; pmem_rdata = 32'hBAD0_BAD0; stray = 0; end
    else if ((pmem_read || pmem_write) && !hold) begin
      if (wcnt == delay) begin pmem_resp = 1; pmem_rdata = rd_val; wcnt = 0; end
      else wcnt++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 0;
    #12;
    chk("rst_strobes", {30'b0, pmem_read, pmem_write}, 0);
    chk("rst_resps", {30'b0, mem_resp_i, mem_resp_d}, 0);
    chk("rst_flags", {30'b0, proto_err, timeout_err}, 0);
    chk("rst_addr", pmem_address, 0);
    idle(1);
    rst = 1;
    idle(1);
    // I read, single-cycle memory
    rd_val = 32'hDEAD_BEEF; delay = 0;
    mem_read_i = 1; mem_address_i = 32'h40;
    push(1'b0, 32'hDEAD_BEEF);
    tick();
    chk("t1_pmem_read", {31'b0, pmem_read}, 1);
    chk("t1_addr", pmem_address, 32'h40);
    chk("t1_early_resp", {31'b0, mem_resp_i}, 0);
    tick();
    chk("t1_resp_i", {31'b0, mem_resp_i}, 1);
    chk("t1_resp_d", {31'b0, mem_resp_d}, 0);
    chk("t1_rdata", mem_rdata_i, 32'hDEAD_BEEF);
    chk("t1_read_drop", {31'b0, pmem_read}, 0);
    tick();
    chk("t1_resp_pulse", {31'b0, mem_resp_i}, 0);
    drain();
    // both ports from reset: D wins the first tie
    rst = 0; idle(1); rst = 1; idle(1);
    delay = 1; rd_val = 32'h0BAD_F00D;
    mem_read_i = 1; mem_address_i = 32'h100;
    mem_write_d = 1; mem_address_d = 32'h200; mem_wdata_d = 32'h1234_5678; mem_byte_enable_d = 4'b0011;
    push(1'b1, 32'h0); push(1'b0, 32'h0BAD_F00D);
    tick();
    chk("t2_d_addr", pmem_address, 32'h200);
    chk("t2_d_write", {30'b0, pmem_write, pmem_read}, 2);
    chk("t2_d_wdata", pmem_wdata, 32'h1234_5678);
    chk("t2_d_be", {28'b0, pmem_byte_enable}, 4'b0011);
    for (int i = 0; i < 20 && !pmem_read; i++) tick();
    chk("t2_i_addr", pmem_address, 32'h100);
    drain();
    idle(3);
    // D address changes while its request is being served
    hold = 1; delay = 0;
    mem_write_d = 1; mem_address_d = 32'h200; mem_wdata_d = 32'h5555_AAAA;
    push(1'b1, 32'h0);
    tick();
    mem_address_d = 32'h300;
    idle(3);
    chk("t3_addr_held", pmem_address, 32'h200);
    chk("t3_strobe_held", {31'b0, pmem_write}, 1);
    hold = 0;
    drain();
    idle(2);
    // D read and write together
    chk("t4_proto_before", {31'b0, proto_err}, 0);
    mem_read_d = 1; mem_write_d = 1; mem_address_d = 32'h400; mem_wdata_d = 32'hAAAA_5555; mem_byte_enable_d = 4'hF;
    push(1'b1, 32'h0);
    tick();
    chk("t4_proto", {31'b0, proto_err}, 1);
    chk("t4_write_only", {30'b0, pmem_write, pmem_read}, 2);
    drain();
    idle(3);
    chk("t4_proto_sticky", {31'b0, proto_err}, 1);
    // memory timeout with TIMEOUT=8
    hold = 1; rd_val = 32'hCAFE_F00D;
    mem_read_i = 1; mem_address_i = 32'h500;
    push(1'b0, 32'hCAFE_F00D);
    tick();
    idle(7);
    chk("t5_no_err_7", {31'b0, timeout_err}, 0);
    tick();
    chk("t5_err_8", {31'b0, timeout_err}, 1);
    chk("t5_read_held", {31'b0, pmem_read}, 1);
    idle(4);
    chk("t5_read_still", {31'b0, pmem_read}, 1);
    hold = 0;
    drain();
    chk("t5_err_sticky", {31'b0, timeout_err}, 1);
    idle(2);
    // reset in the middle of SERVE, then a stray memory response
    hold = 1;
    mem_read_i = 1; mem_address_i = 32'h600;
    tick();
    chk("t6_serving", {31'b0, pmem_read}, 1);
    rst = 0;
    #1;
    chk("t6_rst_strobe", {30'b0, pmem_read, pmem_write}, 0);
    chk("t6_rst_flags", {30'b0, proto_err, timeout_err}, 0);
    chk("t6_rst_resp", {30'b0, mem_resp_i, mem_resp_d}, 0);
    mem_read_i = 0; hold = 0; wcnt = 0;
    tick();
    rst = 1;
    stray = 1;
    idle(4);
    chk("t6_stray_ignored", {29'b0, pmem_read, mem_resp_i, mem_resp_d}, 0);
    delay = 0; rd_val = 32'h1357_9BDF;
    mem_read_d = 1; mem_address_d = 32'h700;
    push(1'b1, 32'h1357_9BDF);
    tick();
    chk("t6_new_addr", pmem_address, 32'h700);
    tick();
    chk("t6_new_resp", {31'b0, mem_resp_d}, 1);
    drain();
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
